chunked_subtractor: RTL
=======================

// Module: chunked_subtractor
// PURPOSE
//  Multi-cycle WIDTH-bit subtractor computing diff = a - b, CHUNK bits per cycle.
//  Borrow ripples through a register between chunks.
//  Companion and inverse of the ripple adder in the arithmetic datapath.
//  Valid/ready handshakes on both input and output.
//  Raises unsigned-borrow, signed-overflow and zero flags for compare and branch logic.
// PARAMETERS
//  WIDTH  32  operand/result width; WIDTH % CHUNK == 0 (elaboration error otherwise)
//  CHUNK   8  bits resolved per BUSY cycle; N = WIDTH/CHUNK cycles per operation
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands a/b valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  a - b modulo 2^WIDTH
//  borrow     out  1      1 iff a < b, unsigned
//  overflow   out  1      signed two's-complement overflow of a - b
//  zero       out  1      1 iff diff == 0
// BEHAVIOUR
//  Reset (async, any state):
//   state=IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, overflow=0, zero=0.
//   Clears the chunk index and the internal borrow register.
//   An operation in progress is discarded; no partial result is ever presented.
//  IDLE:
//   in_ready=1.
//   On in_valid&&in_ready: latch a,b; borrow_reg=0; idx=0; go to BUSY.
//  BUSY (N cycles):
//   in_ready=0.
//   Each edge computes chunk idx: {bout,d} = a[idx] - b[idx] - borrow_reg.
//   Writes d into diff[idx*CHUNK +: CHUNK]; borrow_reg <= bout; idx++.
//   After chunk N-1, go to DONE.
//  DONE:
//   out_valid=1.
//   diff and flags are stable and held until out_ready=1.
//   On out_valid&&out_ready, go to IDLE.
//   in_ready=0 in DONE; no accept in the same cycle as the handoff.
//  Latency: out_valid rises N clock edges after the accepting edge.
//   Minimum issue interval is N+2 cycles.
//  Flags are registered on the final BUSY edge:
//   borrow   = final bout
//   overflow = (a[W-1]!=b[W-1]) && (diff[W-1]!=a[W-1])
//   zero     = ~|diff
//  a/b changes while not in IDLE are ignored; latched copies are used.
//  in_valid may drop without being accepted; no side effect.
//  out_ready is don't-care outside DONE.
//  Arithmetic wraps modulo 2^WIDTH; no saturation.
// STRUCTURE
//  Shared arith package: state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
//   localparam N; index width $clog2(N) (min 1).
//  Sub-module full_subtractor(a,b,bin -> d,bout), instantiated CHUNK times
//   in a generate loop to form the per-cycle ripple chunk:
//   d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
// TESTING
//  5 - 3:
//   -> diff=0x00000002, borrow=0, overflow=0, zero=0; out_valid 4 edges after accept.
//  3 - 5:
//   -> diff=0xFFFFFFFE, borrow=1, overflow=0, zero=0.
//  0x80000000 - 1:
//   -> diff=0x7FFFFFFF, borrow=0, overflow=1; 0x7FFFFFFF - 0xFFFFFFFF -> overflow=1.
//  0x00000100 - 1:
//   -> diff=0x000000FF (borrow crosses the chunk 0/1 boundary).
//  0x1234ABCD - 0x1234ABCD:
//   -> diff=0, zero=1, borrow=0.
//  Backpressure: hold out_ready=0 for 5 cycles in DONE
//   -> outputs stable, in_ready=0, new in_valid ignored;
//   -> then out_ready=1 -> IDLE next edge.
//  Reset after 2 BUSY cycles:
//   -> out_valid=0 and in_ready=1 immediately;
//   -> next op 7 - 7 gives zero=1 (no stale borrow).

Source files
------------

// File: rtl/chunked_subtractor_pkg.sv
// Shared definitions for the chunked subtractor: FSM encoding and index sizing.
package chunked_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    // Chunk index width; a single-chunk configuration still gets a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunked_subtractor_full_subtractor.sv
// One-bit full subtractor; a chain of these forms the per-cycle ripple chunk.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/chunked_subtractor.sv
// Multi-cycle subtractor: resolves CHUNK bits of a - b per cycle, carrying the
// borrow in a register between chunks, with valid/ready on both sides.
module chunked_subtractor
    import chunked_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = idx_w(N);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("chunked_subtractor: WIDTH must be a multiple of CHUNK");
    end

    sub_state_t       state_q;
    logic [IW-1:0]    idx_q;
    logic             bor_q;
    logic [WIDTH-1:0] a_q, b_q, diff_q;
    logic [WIDTH-1:0] diff_d;
    logic             borrow_q, overflow_q, zero_q;

    logic [CHUNK-1:0] a_chunk, b_chunk, d_chunk;
    logic [CHUNK:0]   bchain;
    logic             last_chunk;

    assign a_chunk    = a_q[idx_q*CHUNK +: CHUNK];
    assign b_chunk    = b_q[idx_q*CHUNK +: CHUNK];
    assign bchain[0]  = bor_q;
    assign last_chunk = (idx_q == IW'(N - 1));

    for (genvar i = 0; i < CHUNK; i++) begin : g_fs
        full_subtractor u_fs (
            .a    (a_chunk[i]),
            .b    (b_chunk[i]),
            .bin  (bchain[i]),
            .d    (d_chunk[i]),
            .bout (bchain[i+1])
        );
    end

    // Full result as it will stand after this edge; flags derive from it on the last chunk.
    always_comb begin
        diff_d = diff_q;
        diff_d[idx_q*CHUNK +: CHUNK] = d_chunk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            bor_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        bor_q   <= 1'b0;
                        idx_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    diff_q <= diff_d;
                    bor_q  <= bchain[CHUNK];
                    idx_q  <= idx_q + 1'b1;
                    if (last_chunk) begin
                        borrow_q   <= bchain[CHUNK];
                        overflow_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                      (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                        zero_q     <= ~|diff_d;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule
